// File: rtl/ram_pkg.sv
// Shared definitions for the ram_responder memory slice.
// - size_t  : access width codes carried on the size port (2'b11 is treated as a word).
// - state_t : handshake FSM encoding.
package ram_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ACK  = 2'b10
  } state_t;

endpackage

// File: rtl/mem_byte_array.sv
// Four byte-lane RAM arrays forming a 32-bit word store of DEPTH bytes.
// Lane 3 holds the most significant byte of each word, which is the byte at the
// lowest address in the big-endian view.
// Ports:
//   clk    in   system clock
//   we     in   per-lane write enables, bit k writes wdata[8k+7:8k]
//   index  in   word index (byte address / 4)
//   wdata  in   lane-replicated write word
//   rdata  out  word at index, combinational read
module mem_byte_array #(
  parameter int DEPTH = 512,
  parameter int IW    = 7
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [IW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH/4];

    always_ff @(posedge clk) begin
      if (we[l]) mem[index] <= wdata[8*l +: 8];
    end

    assign rdata[8*l +: 8] = mem[index];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the CPU MOV/MOC handshake. A request is latched in
// IDLE, waits WAIT_CYCLES extra cycles in BUSY, then performs a big-endian byte,
// halfword or word access and raises MOC until the initiator drops MOV.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   MOV      in   memory operation valid, held until MOC is seen
//   RW       in   1 = read, 0 = write
//   size     in   00 byte, 01 halfword, 10/11 word
//   sgn      in   sign-extend byte/halfword reads
//   addr     in   byte address
//   DataIn   in   right-justified write data
//   DataOut  out  right-justified read data, holds last read
//   MOC      out  memory operation complete
module ram_responder
  import ram_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (AW > 2) ? AW - 2 : 1;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            moc_n;
  logic            accept;
  logic            commit;

  logic            rw_q;
  logic [1:0]      size_q;
  logic            sgn_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     data_q;

  logic [IW-1:0]   index;
  logic [3:0]      we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;

  // Address bits above the RAM size alias onto the same locations.
  logic            unused_addr;
  assign unused_addr = ^addr[31:AW];

  // Lane k carries bits [8k+7:8k] of the word; byte offset 0 is lane 3.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    if (sz == SZ_BYTE)      lane_mask = 4'b1000 >> off;
    else if (sz == SZ_HALF) lane_mask = off[1] ? 4'b0011 : 4'b1100;
    else                    lane_mask = 4'b1111;
  endfunction

  // Replicate the narrow write value onto every lane it could land in.
  function automatic logic [31:0] steer_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == SZ_BYTE)      steer_wdata = {4{d[7:0]}};
    else if (sz == SZ_HALF) steer_wdata = {2{d[15:0]}};
    else                    steer_wdata = d;
  endfunction

  function automatic logic [31:0] extract_read(input logic [1:0] sz, input logic sg,
                                               input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * (3 - off)));
    h = off[1] ? w[15:0] : w[31:16];
    if (sz == SZ_BYTE)      extract_read = {{24{sg & b[7]}}, b};
    else if (sz == SZ_HALF) extract_read = {{16{sg & h[15]}}, h};
    else                    extract_read = w;
  endfunction

  if (AW > 2) begin : g_idx
    assign index = addr_q[AW-1:2];
  end else begin : g_idx1
    assign index = '0;
  end

  // A commit on the same edge as reset must not reach the RAM.
  assign we    = (commit && !rw_q && !reset) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
  assign wdata = steer_wdata(size_q, data_q);

  mem_byte_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .index (index),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    moc_n   = MOC;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        moc_n = 1'b0;
        if (MOV) begin
          accept  = 1'b1;
          cnt_n   = 4'(WAIT_CYCLES);
          state_n = BUSY;
        end
      end
      BUSY: begin
        // Dropping MOV wins over a pending completion.
        if (!MOV) begin
          state_n = IDLE;
        end else if (cnt == 4'd0) begin
          commit  = 1'b1;
          moc_n   = 1'b1;
          state_n = ACK;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ACK: begin
        if (!MOV) begin
          moc_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      MOC     <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      MOC   <= moc_n;
      if (commit && rw_q) DataOut <= extract_read(size_q, sgn_q, addr_q[1:0], rdata);
    end
  end

  // Request capture: inputs are only looked at on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q   <= RW;
      size_q <= size;
      sgn_q  <= sgn;
      addr_q <= addr[AW-1:0];
      data_q <= DataIn;
    end
  end

endmodule
